// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the pipelined ALU.
package alu_pkg;

  // Opcode encoding; 3'b001 and 3'b111 are intentionally left undefined
  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_t;

  // Width of the raw opcode field carried through the pipe
  localparam int OP_W = 3;

  // True for the opcodes that use the split carry chain
  function automatic logic is_arith(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUBTRACT);
  endfunction

  // True when the B operand must be inverted and a carry-in of one injected
  function automatic logic is_sub(alu_op_t op);
    return (op == ALU_SUBTRACT);
  endfunction

  // Reinterpret a raw opcode field as the enum (undefined codes survive the cast)
  function automatic alu_op_t to_op(logic [OP_W-1:0] raw);
    return alu_op_t'(raw);
  endfunction

endpackage

// File: rtl/alu_pipe_add_slice.sv
// One half of the split carry chain: N-bit adder that also exposes the
// carry into its top bit so signed overflow can be formed downstream.
module add_slice #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] total;

  // Ripple-free behavioural add; carry into the MSB recovered from the sum bit
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    sum   = total[N-1:0];
    cout  = total[N];
    c_msb = a[N-1] ^ b[N-1] ^ total[N-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides. The low half of
// the add/sub is done in stage 1, the high half in stage 2, so each stage
// only carries a WIDTH/2 adder.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int HALF = WIDTH / 2;

  // Handshake bookkeeping
  logic             s1_advance;
  logic             s2_drain;
  logic             accept;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q,    s1_op_d;
  logic [HALF-1:0]  s1_a_hi_q,  s1_a_hi_d;
  logic [HALF-1:0]  s1_b_hi_q,  s1_b_hi_d;
  logic [HALF-1:0]  s1_lo_q,    s1_lo_d;
  logic             s1_cmid_q,  s1_cmid_d;

  // Stage 2 / output registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             negative_q,  negative_d;
  logic             zero_q,      zero_d;
  logic             overflow_q,  overflow_d;
  logic             carry_q,     carry_d;

  // Stage 1 datapath
  alu_op_t          in_op;
  logic [WIDTH-1:0] b_eff;
  logic             lo_cin;
  logic [HALF-1:0]  lo_sum;
  logic             lo_cout;
  logic             lo_c_msb_unused;
  logic [HALF-1:0]  lo_res;

  // Stage 2 datapath
  alu_op_t          s1_op;
  logic [HALF-1:0]  hi_sum;
  logic             hi_cout;
  logic             hi_c_msb;
  logic [HALF-1:0]  hi_res;
  logic [WIDTH-1:0] full_res;

  assign in_op = to_op(cntrl);
  assign s1_op = to_op(s1_op_q);

  // Ready propagates backwards combinationally; it never looks at in_valid
  always_comb begin
    s2_drain   = out_valid_q && out_ready;
    s1_advance = s1_valid_q && (!out_valid_q || out_ready);
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;
  end

  // Next-state of the two valid bits: fill on accept/advance, empty on leave
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
    end else if (s2_drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Subtraction is A + ~B + 1, so the inversion and carry-in are applied here
  always_comb begin
    b_eff  = is_sub(in_op) ? ~B : B;
    lo_cin = is_sub(in_op);
  end

  add_slice #(.N(HALF)) u_lo_add (
    .a     (A[HALF-1:0]),
    .b     (b_eff[HALF-1:0]),
    .cin   (lo_cin),
    .sum   (lo_sum),
    .cout  (lo_cout),
    .c_msb (lo_c_msb_unused)
  );

  // Low half of the result for every opcode; undefined codes give zero
  always_comb begin
    case (in_op)
      ALU_ADD,
      ALU_SUBTRACT: lo_res = lo_sum;
      ALU_AND:      lo_res = A[HALF-1:0] & B[HALF-1:0];
      ALU_OR:       lo_res = A[HALF-1:0] | B[HALF-1:0];
      ALU_XOR:      lo_res = A[HALF-1:0] ^ B[HALF-1:0];
      ALU_PASS_B:   lo_res = B[HALF-1:0];
      default:      lo_res = '0;
    endcase
  end

  // Stage 1 data capture on accept; otherwise hold
  always_comb begin
    s1_op_d   = s1_op_q;
    s1_a_hi_d = s1_a_hi_q;
    s1_b_hi_d = s1_b_hi_q;
    s1_lo_d   = s1_lo_q;
    s1_cmid_d = s1_cmid_q;
    if (accept) begin
      s1_op_d   = cntrl;
      s1_a_hi_d = A[WIDTH-1:HALF];
      s1_b_hi_d = b_eff[WIDTH-1:HALF];
      s1_lo_d   = lo_res;
      s1_cmid_d = is_arith(in_op) & lo_cout;
    end
  end

  add_slice #(.N(HALF)) u_hi_add (
    .a     (s1_a_hi_q),
    .b     (s1_b_hi_q),
    .cin   (s1_cmid_q),
    .sum   (hi_sum),
    .cout  (hi_cout),
    .c_msb (hi_c_msb)
  );

  // High half of the result; B-hi is already un-inverted for logic opcodes
  always_comb begin
    case (s1_op)
      ALU_ADD,
      ALU_SUBTRACT: hi_res = hi_sum;
      ALU_AND:      hi_res = s1_a_hi_q & s1_b_hi_q;
      ALU_OR:       hi_res = s1_a_hi_q | s1_b_hi_q;
      ALU_XOR:      hi_res = s1_a_hi_q ^ s1_b_hi_q;
      ALU_PASS_B:   hi_res = s1_b_hi_q;
      default:      hi_res = '0;
    endcase
    full_res = {hi_res, s1_lo_q};
  end

  // Output capture only on stage-1 advance, so results hold under backpressure
  always_comb begin
    result_d   = result_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    carry_d    = carry_q;
    if (s1_advance) begin
      result_d   = full_res;
      negative_d = full_res[WIDTH-1];
      zero_d     = (full_res == '0);
      overflow_d = is_arith(s1_op) & (hi_c_msb ^ hi_cout);
      carry_d    = is_arith(s1_op) & hi_cout;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
    end
  end

  // Stage 1 data registers need no reset; they are qualified by s1_valid_q
  always_ff @(posedge clk) begin
    s1_op_q   <= s1_op_d;
    s1_a_hi_q <= s1_a_hi_d;
    s1_b_hi_q <= s1_b_hi_d;
    s1_lo_q   <= s1_lo_d;
    s1_cmid_q <= s1_cmid_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors with hand-computed
// results, backpressure and reset scenarios, and a scoreboarded random stream.
module tb_alu_pipe;

  localparam int WIDTH = 64;
  localparam int RAND_N = 300;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  int assert_count = 0;
  int fail_count   = 0;

  logic [63:0] bp_a   [4] = '{64'd10, 64'd20, 64'd30, 64'd40};
  logic [63:0] bp_exp [4] = '{64'd11, 64'd21, 64'd31, 64'd41};
  logic [67:0] sb_q[$];

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction through an empty pipe; flags packed as {n,z,v,c}
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_res, input logic [3:0] exp_flags);
    in_valid  = 1'b1;
    cntrl     = op;
    A         = a;
    B         = b;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    checkOutput({tag, "_not_yet"}, 64'(out_valid), 64'd0);
    tick();
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_flags"}, 64'({negative, zero, overflow, carry_out}), 64'(exp_flags));
    tick();
    checkOutput({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // Reference model written from the arithmetic definitions: {n,z,v,c,result}
  function automatic logic [67:0] ref_alu(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [64:0] wide;
    logic [63:0] r;
    logic        v;
    logic        c;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[63:0];
        c    = wide[64];
        v    = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      3'b000:  r = b;
      default: r = '0;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  // Hard stop if anything stalls forever
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  idx;
    int  rx;
    int  first_cyc;
    int  last_cyc;
    int  sent;
    int  xfers;
    logic fire_in;
    logic fire_out;
    logic [67:0] exp_v;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    cntrl     = 3'b000;

    // Reset state
    #23;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Directed vectors
    applyStimulus("add_cross",  3'b010, 64'h0000_0000_FFFF_FFFF, 64'd1,
                  64'h0000_0001_0000_0000, 4'b0000);
    applyStimulus("add_ovf",    3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h8000_0000_0000_0000, 4'b1010);
    applyStimulus("add_wrap",   3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h0000_0000_0000_0000, 4'b0101);
    applyStimulus("add_minmin", 3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  64'h0000_0000_0000_0000, 4'b0111);
    applyStimulus("sub_0m1",    3'b011, 64'd0, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    applyStimulus("sub_eq",     3'b011, 64'd5, 64'd5,
                  64'h0000_0000_0000_0000, 4'b0101);
    applyStimulus("sub_ovf",    3'b011, 64'h8000_0000_0000_0000, 64'd1,
                  64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    applyStimulus("sub_cross",  3'b011, 64'h0000_0001_0000_0000, 64'd1,
                  64'h0000_0000_FFFF_FFFF, 4'b0001);
    applyStimulus("and",        3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                  64'hF000_F000_F000_F000, 4'b1000);
    applyStimulus("or",         3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                  64'hFFF0_FFF0_FFF0_FFF0, 4'b1000);
    applyStimulus("xor",        3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                  64'h0FF0_0FF0_0FF0_0FF0, 4'b0000);
    applyStimulus("pass_b",     3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                  64'hFF00_FF00_FF00_FF00, 4'b1000);
    applyStimulus("undef_111",  3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h0000_0000_0000_0000, 4'b0100);
    applyStimulus("undef_001",  3'b001, 64'h1234_5678_9ABC_DEF0, 64'h1,
                  64'h0000_0000_0000_0000, 4'b0100);

    // Backpressure: with out_ready low only two transactions fit
    idx       = 0;
    out_ready = 1'b0;
    cntrl     = 3'b010;
    B         = 64'd1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) A = bp_a[idx];
      #1;
      fire_in = in_valid && in_ready;
      tick();
      if (fire_in) idx++;
    end
    #1;
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_head", result, 64'd11);
    tick();
    checkOutput("bp_hold", result, 64'd11);
    checkOutput("bp_hold_flags", 64'({negative, zero, overflow, carry_out}), 64'd0);

    // Release backpressure: all four emerge in order on consecutive cycles
    rx        = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) A = bp_a[idx];
      out_ready = 1'b1;
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checkOutput("bp_order", result, bp_exp[rx]);
        if (rx == 0) first_cyc = cyc;
        last_cyc = cyc;
        rx++;
      end
      tick();
      if (fire_in) idx++;
    end
    in_valid = 1'b0;
    checkOutput("bp_rx_count", 64'(rx), 64'd4);
    checkOutput("bp_tx_count", 64'(idx), 64'd4);
    checkOutput("bp_back_to_back", 64'(last_cyc - first_cyc), 64'd3);
    tick();
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    cntrl     = 3'b010;
    A         = 64'd100;
    B         = 64'd1;
    in_valid  = 1'b1;
    tick();
    A = 64'd200;
    tick();
    in_valid = 1'b0;
    checkOutput("mid_full", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_result", result, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("mid_rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    xfers     = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      if (out_valid && out_ready) xfers++;
      tick();
    end
    checkOutput("mid_no_xfer", 64'(xfers), 64'd0);
    checkOutput("mid_rel_result", result, 64'd0);

    // Random stream against the reference model
    sent = 0;
    rx   = 0;
    sb_q.delete();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && rx < RAND_N; cyc++) begin
      if (!in_valid && sent < RAND_N && ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        cntrl    = 3'($urandom_range(0, 7));
        A        = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       B = A;
          1:       B = 64'($urandom_range(0, 3));
          default: B = {$urandom, $urandom};
        endcase
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (sb_q.size() == 0) begin
          checkOutput("rand_unexpected", 64'd1, 64'd0);
        end else begin
          exp_v = sb_q.pop_front();
          checkOutput("rand_result", result, exp_v[63:0]);
          checkOutput("rand_flags", 64'({negative, zero, overflow, carry_out}), 64'(exp_v[67:64]));
        end
        rx++;
      end
      if (fire_in) begin
        sb_q.push_back(ref_alu(cntrl, A, B));
        sent++;
      end
      tick();
      if (fire_in) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("rand_rx_count", 64'(rx), 64'(RAND_N));
    checkOutput("rand_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
